adc_spi_sampler: RTL and testbench

- Upstream front end for the collector. Runs one MCP3204-style SPI conversion frame on the ADC board (MIKROE-340) per request and returns a 12-bit sample.
- The sample is presented over a valid/ready handshake, so the collector's storage logic can accept it at its own pace.
- Generates the ~100 kHz serial clock, chip select and command bits from the 50 MHz system clock.

---
 rtl/adc_spi_sampler_pkg.sv | 44 ++++
 rtl/adc_spi_sampler_half_tick_gen.sv | 39 +++
 rtl/adc_spi_sampler.sv | 174 +++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_sampler_pkg.sv
//==============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the MCP3204-style SPI sampler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package adc_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Rising-edge index within a frame (1..19)
  typedef logic [4:0] edge_t;

  localparam int    SAMPLE_W        = 12;
  localparam edge_t N_EDGES         = 5'd19;
  localparam edge_t N_CMD           = 5'd5;
  localparam edge_t FIRST_DATA_EDGE = 5'd8;

  // Command bit presented to the ADC on rising edge n:
  // start, SGL/DIFF, D2 (always 0), D1, D0.
  function automatic logic cmd_bit(input edge_t n, input logic sgl,
                                   input logic [1:0] ch);
    logic b;
    case (n)
      5'd1:    b = 1'b1;
      5'd2:    b = sgl;
      5'd3:    b = 1'b0;
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_spi_sampler_half_tick_gen.sv
//==============================================================================
// Module      : half_tick_gen
// Description : Free-running divider that pulses tick once every CLK_DIV
//               cycles while enabled; held at zero when disabled so the first
//               tick after enable arrives exactly CLK_DIV cycles later.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module half_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..CLK_DIV-1 while enabled; clear whenever disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!en || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/adc_spi_sampler.sv
//==============================================================================
// Module      : adc_spi_sampler
// Description : Runs one MCP3204-style SPI conversion frame per request and
//               returns the 12-bit result over a valid/ready handshake.
//               SCLK, CS and MOSI are all driven straight from flops.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = 250,
  parameter bit SINGLE_ENDED = 1'b1,
  parameter int HOLD_HALVES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          ch_sel,
  output logic                busy,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                CS,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int            HW     = (HOLD_HALVES < 1) ? 1 : $clog2(HOLD_HALVES + 1);
  localparam logic [HW-1:0] c_HOLD = HW'(HOLD_HALVES);

  state_t              r_state;
  logic                r_cs;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_busy;
  logic                r_valid;
  logic [SAMPLE_W-1:0] r_sample;
  logic [SAMPLE_W-1:0] r_shift;
  logic [1:0]          r_ch;
  edge_t               r_edge;
  logic                r_tail;
  logic [HW-1:0]       r_hold;

  logic                w_tick;
  logic                w_tick_en;
  edge_t               w_next_edge;
  logic                w_hold_full;
  logic                w_hold_done;

  assign w_tick_en   = (r_state != IDLE);
  assign w_next_edge = r_edge + edge_t'(1);
  assign w_hold_full = (r_hold == c_HOLD);
  // The hold counts as expired already in the cycle whose tick completes it,
  // which keeps the start-to-start spacing at (40 + HOLD_HALVES)*CLK_DIV + 1.
  assign w_hold_done = w_hold_full || (w_tick && ((r_hold + HW'(1)) == c_HOLD));

  half_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tick_en),
    .tick (w_tick)
  );

  // Frame sequencer: command shift-out, data capture and result handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_sample <= '0;
      r_shift  <= '0;
      r_ch     <= 2'b00;
      r_edge   <= '0;
      r_tail   <= 1'b0;
      r_hold   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cs   <= 1'b1;
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          if (start) begin
            r_ch    <= ch_sel;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_mosi  <= cmd_bit(edge_t'(1), SINGLE_ENDED, ch_sel);
            r_shift <= '0;
            r_edge  <= '0;
            r_tail  <= 1'b0;
            r_hold  <= '0;
            r_state <= SETUP;
          end
        end

        SETUP: begin
          // CS-to-first-edge setup time is one full half-period
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_edge  <= edge_t'(1);
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (w_tick) begin
            if (r_tail) begin
              // Trailing half-period after the last falling edge is over
              r_cs     <= 1'b1;
              r_sample <= r_shift;
              r_valid  <= 1'b1;
              r_tail   <= 1'b0;
              r_hold   <= '0;
              r_state  <= DONE;
            end else if (r_sclk) begin
              // Falling edge: only place MOSI may change
              r_sclk <= 1'b0;
              r_mosi <= (w_next_edge <= N_CMD) ?
                        cmd_bit(w_next_edge, SINGLE_ENDED, r_ch) : 1'b0;
            end else if (r_edge == N_EDGES) begin
              r_tail <= 1'b1;
            end else begin
              // Rising edge: capture data bits MSB first
              r_sclk <= 1'b1;
              r_edge <= w_next_edge;
              if (w_next_edge >= FIRST_DATA_EDGE) begin
                r_shift <= {r_shift[SAMPLE_W-2:0], MISO};
              end
            end
          end
        end

        DONE: begin
          r_cs <= 1'b1;
          if (r_valid && sample_ready) begin
            r_valid <= 1'b0;
          end
          if (w_tick && !w_hold_full) begin
            r_hold <= r_hold + HW'(1);
          end
          if (!r_valid && w_hold_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cs    <= 1'b1;
          r_sclk  <= 1'b0;
          r_mosi  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign CS           = r_cs;
  assign SCLK         = r_sclk;
  assign MOSI         = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
//==============================================================================
// Module      : tb_adc_spi_sampler
// Description : Directed self-checking bench for adc_spi_sampler with a
//               behavioural MCP3204 model on each of two instances
//               (default divider and CLK_DIV = 2).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_spi_sampler;

  localparam int LIM = 50000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: default parameters ----------------
  logic        start_a, ready_a, busy_a, valid_a, cs_a, sclk_a, mosi_a;
  logic        miso_a = 1'b0;
  logic [1:0]  ch_a;
  logic [11:0] sample_a;

  adc_spi_sampler u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (start_a),
    .ch_sel       (ch_a),
    .busy         (busy_a),
    .sample       (sample_a),
    .sample_valid (valid_a),
    .sample_ready (ready_a),
    .CS           (cs_a),
    .SCLK         (sclk_a),
    .MOSI         (mosi_a),
    .MISO         (miso_a)
  );

  // ---------------- instance B: CLK_DIV = 2 ----------------
  logic        start_b, ready_b, busy_b, valid_b, cs_b, sclk_b, mosi_b;
  logic        miso_b = 1'b0;
  logic [1:0]  ch_b;
  logic [11:0] sample_b;

  adc_spi_sampler #(.CLK_DIV(2)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (start_b),
    .ch_sel       (ch_b),
    .busy         (busy_b),
    .sample       (sample_b),
    .sample_valid (valid_b),
    .sample_ready (ready_b),
    .CS           (cs_b),
    .SCLK         (sclk_b),
    .MOSI         (mosi_b),
    .MISO         (miso_b)
  );

  // ---------------- ADC models ----------------
  // Rising edges are counted per frame; data bit 11 is presented after the
  // falling edge of edge 7 so it is stable at edge 8, bit 0 at edge 19.
  logic [11:0] a_val = 12'h000;
  logic [4:0]  a_cmd = 5'b0;
  int a_rise = 0, a_edges = 0, a_frames = 0, a_t1 = 0, a_t19 = 0;

  always @(posedge sclk_a or posedge cs_a) begin
    if (cs_a) begin
      a_edges <= a_rise;
      a_rise  <= 0;
    end else begin
      a_rise <= a_rise + 1;
      if (a_rise < 5)   a_cmd[3'(4 - a_rise)] <= mosi_a;
      if (a_rise == 0)  a_t1  <= cyc;
      if (a_rise == 18) a_t19 <= cyc;
    end
  end

  always @(negedge sclk_a or posedge cs_a) begin
    if (cs_a)                            miso_a <= 1'b0;
    else if (a_rise >= 7 && a_rise <= 18) miso_a <= a_val[4'(18 - a_rise)];
    else                                 miso_a <= 1'b0;
  end

  always @(negedge cs_a) a_frames <= a_frames + 1;

  logic [11:0] b_val = 12'h000;
  logic [4:0]  b_cmd = 5'b0;
  int b_rise = 0, b_edges = 0, b_t1 = 0, b_t19 = 0;

  always @(posedge sclk_b or posedge cs_b) begin
    if (cs_b) begin
      b_edges <= b_rise;
      b_rise  <= 0;
    end else begin
      b_rise <= b_rise + 1;
      if (b_rise < 5)   b_cmd[3'(4 - b_rise)] <= mosi_b;
      if (b_rise == 0)  b_t1  <= cyc;
      if (b_rise == 18) b_t19 <= cyc;
    end
  end

  always @(negedge sclk_b or posedge cs_b) begin
    if (cs_b)                            miso_b <= 1'b0;
    else if (b_rise >= 7 && b_rise <= 18) miso_b <= b_val[4'(18 - b_rise)];
    else                                 miso_b <= 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start a frame on A (must be idle) and count clk edges to sample_valid
  task automatic frame_a(input bit keep_start, output int lat);
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    check("start_ack", {busy_a, cs_a, mosi_a}, 3'b101);
    if (!keep_start) start_a = 1'b0;
    lat = 0;
    while (!valid_a && lat < LIM) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    while (busy_a && n < LIM) begin
      @(posedge clk);
      n++;
      #1;
    end
    check(tag, busy_a, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, gap, bad, f0;

    rst = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; ch_a = 2'b00;
    start_b = 1'b0; ready_b = 1'b1; ch_b = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {cs_a, sclk_a, mosi_a, busy_a, valid_a, sample_a}, 17'h10000);
    check("reset_b", {cs_b, sclk_b, mosi_b, busy_b, valid_b, sample_b}, 17'h10000);
    @(negedge clk);
    rst = 1'b1;

    // CLK_DIV = 2 instance
    b_val = 12'h5A3;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    n = 0;
    while (!valid_b && n < LIM) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("b_latency", n, 80);
    check("b_sample", sample_b, 12'h5A3);
    check("b_sclk_span", b_t19 - b_t1, 72);
    check("b_edges", b_edges, 19);
    check("b_cmd", b_cmd, 5'b11000);

    // Single frame, channel 2, ready high
    ch_a = 2'b10; a_val = 12'hA5C; ready_a = 1'b1;
    frame_a(1'b0, n);
    check("t1_latency", n, 10000);
    check("t1_sample", sample_a, 12'hA5C);
    check("t1_cmd", a_cmd, 5'b11010);
    check("t1_edges", a_edges, 19);
    check("t1_sclk_span", a_t19 - a_t1, 9000);
    check("t1_cs_done", cs_a, 1'b1);
    @(posedge clk);
    #1;
    check("t1_valid_drop", valid_a, 1'b0);
    wait_idle_a("t1_idle");

    // Back-to-back frames with start held high
    a_val = 12'hFFF;
    frame_a(1'b1, n);
    check("t2_latency0", n, 10000);
    check("t2_sample0", sample_a, 12'hFFF);
    check("t2_edges0", a_edges, 19);
    a_val = 12'h000;
    gap = 1;
    @(posedge clk);
    #1;
    check("t2_ack0", valid_a, 1'b0);
    ready_a = 1'b0;
    while (cs_a && gap < LIM) begin
      @(posedge clk);
      gap++;
      #1;
    end
    check("t2_cs_gap", gap, 501);
    n = 0;
    while (!valid_a && n < LIM) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("t2_latency1", n, 10000);
    check("t2_sample1", sample_a, 12'h000);
    check("t2_edges1", a_edges, 19);
    check("t2_sclk_span1", a_t19 - a_t1, 9000);

    // Consumer stalls: valid held, no new frame despite start
    f0 = a_frames;
    bad = 0;
    repeat (20000) begin
      @(posedge clk);
      #1;
      if (!valid_a || sample_a !== 12'h000 || !cs_a || !busy_a) bad++;
    end
    check("t3_stall_hold", bad, 0);
    check("t3_no_frame", a_frames - f0, 0);
    start_a = 1'b0;
    @(negedge clk);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("t3_valid_drop", valid_a, 1'b0);
    ready_a = 1'b0;
    @(posedge clk);
    #1;
    check("t3_idle", busy_a, 1'b0);

    // Repeated start pulses and ch_sel change mid-frame
    ready_a = 1'b1; a_val = 12'h3C7;
    f0 = a_frames;
    @(negedge clk);
    ch_a = 2'b01;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n = 0;
    while (!valid_a && n < LIM) begin
      @(posedge clk);
      n++;
      #1;
      start_a = ((n % 97) == 0);
      if (a_rise >= 3) ch_a = 2'b10;
    end
    start_a = 1'b0;
    check("t4_latency", n, 10000);
    check("t4_cmd", a_cmd, 5'b11001);
    check("t4_sample", sample_a, 12'h3C7);
    wait_idle_a("t4_idle");
    repeat (600) @(posedge clk);
    #1;
    check("t4_one_frame", a_frames - f0, 1);

    // Asynchronous reset at rising edge 10, then a clean frame
    ch_a = 2'b11; a_val = 12'h7E1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n = 0;
    while (a_rise < 10 && n < LIM) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("t5_edge10", a_rise, 10);
    rst = 1'b0;
    #1;
    check("t5_async_rst", {cs_a, sclk_a, mosi_a, busy_a, valid_a, sample_a}, 17'h10000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    frame_a(1'b0, n);
    check("t5_latency", n, 10000);
    check("t5_sample", sample_a, 12'h7E1);
    check("t5_cmd", a_cmd, 5'b11011);
    check("t5_edges", a_edges, 19);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
